// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master byte engine between NUM_REQ requesters.
// Latches the winner's address/data, runs the start/ready handshake, returns ack or timeout err.
module i2c_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     err,
    output logic                   busy,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    output logic                   m_start,
    input  logic                   m_ready
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_RST  = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COOL} state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [PW-1:0]      last;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      idx;
    logic               win_vld;
    logic [6:0]         win_addr;
    logic [7:0]         win_data;
    logic [NUM_REQ-1:0] owner_oh;

    // Scan downward so the closest requester after 'last' is the final (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(last) + k) % NUM_REQ);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_addr = req_addr[7*i +: 7];
                win_data = req_data[8*i +: 8];
            end
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            last    <= P_RST;
            owner   <= '0;
            grant   <= '0;
            ack     <= '0;
            err     <= '0;
            busy    <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_start <= 1'b0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    if (win_vld && m_ready) begin
                        owner   <= win_idx;
                        grant   <= NUM_REQ'(1) << win_idx;
                        m_addr  <= win_addr;
                        m_data  <= win_data;
                        m_start <= 1'b1;
                        timer   <= '0;
                        busy    <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        timer   <= '0;
                        state   <= WAIT;
                    end else if (timer == T_LAST) begin
                        err     <= owner_oh;
                        m_start <= 1'b0;
                        state   <= COOL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT: begin
                    if (m_ready) begin
                        ack   <= owner_oh;
                        state <= COOL;
                    end else if (timer == T_LAST) begin
                        err   <= owner_oh;
                        state <= COOL;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COOL: begin
                    // Requesters drop req during this cycle, so the next arbitration never sees a stale one.
                    grant <= '0;
                    last  <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed and randomized bench for i2c_arbiter with a transaction-level round-robin model
// and a behavioural i2c_master handshake responder.
`define CHK(tag, obs, ev) \
    begin \
        checks++; \
        assert ((obs) === (ev)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (ev)); \
        end \
    end

module tb_i2c_arbiter;
    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant, ack, err;
    logic           busy;
    logic [6:0]     m_addr;
    logic [7:0]     m_data;
    logic           m_start;
    logic           m_ready;

    logic mst_rdy;
    logic hold_low;
    logic mst_ignore;
    int   mst_d1, mst_d2;
    int   checks, errors;
    int   last_m;

    assign m_ready = mst_rdy & ~hold_low;

    i2c_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .grant(grant), .ack(ack), .err(err), .busy(busy),
        .m_addr(m_addr), .m_data(m_data), .m_start(m_start), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master: sees start, drops ready d1 cycles later, raises it again after d2 more cycles.
    initial begin
        mst_rdy = 1'b1;
        mst_d1  = 1;
        mst_d2  = 1;
        forever begin
            @(negedge clk);
            if (!mst_ignore && m_start && m_ready) begin
                mst_d1 = $urandom_range(1, 6);
                mst_d2 = $urandom_range(1, 8);
                repeat (mst_d1) @(negedge clk);
                mst_rdy = 1'b0;
                repeat (mst_d2) @(negedge clk);
                mst_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checks += 4;
            if ((ack & err) !== {N{1'b0}}) begin
                errors++;
                $error("FAIL excl observed=%0h expected=0", ack & err);
            end
            if (((ack | err) & ~grant) !== {N{1'b0}}) begin
                errors++;
                $error("FAIL owner_only observed=%0h expected=0", (ack | err) & ~grant);
            end
            if (busy !== (|grant)) begin
                errors++;
                $error("FAIL busy_grant observed=%0h expected=%0h", busy, |grant);
            end
            if ((m_start & ~(|grant)) !== 1'b0) begin
                errors++;
                $error("FAIL start_owned observed=%0h expected=0", m_start & ~(|grant));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++)
            if (r[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    task automatic chk_reset_vals();
        `CHK("rst_grant", grant, '0)
        `CHK("rst_ack", ack, '0)
        `CHK("rst_err", err, '0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_start", m_start, 1'b0)
        `CHK("rst_addr", m_addr, 7'h00)
        `CHK("rst_data", m_data, 8'h00)
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset  = 1'b1;
        last_m = N - 1;
    endtask

    // exp_plat < 0: latency follows the master (ack on the edge after ready returns high).
    task automatic run_txn(input bit exp_err, input int exp_plat, input int exp_glat,
                           input bit stall, input bit scr, input bit rearm);
        int         w, glat, plat;
        logic [N-1:0] oh;
        logic [6:0] ea;
        logic [7:0] ed;
        w  = pick(req, last_m);
        oh = N'(1) << w;
        ea = req_addr[7*w +: 7];
        ed = req_data[8*w +: 8];
        glat = 0;
        do begin
            @(negedge clk);
            glat++;
        end while (grant == '0 && glat < 40);
        `CHK("grant", grant, oh)
        if (exp_glat > 0) `CHK("grant_lat", glat, exp_glat)
        `CHK("m_addr", m_addr, ea)
        `CHK("m_data", m_data, ed)
        `CHK("m_start", m_start, 1'b1)
        `CHK("busy", busy, 1'b1)
        hold_low = stall;
        if (scr) begin
            req_addr[7*w +: 7] = ~ea;
            req_data[8*w +: 8] = ~ed;
            req[w] = 1'b0;
        end
        plat = 0;
        do begin
            @(negedge clk);
            plat++;
            `CHK("hold_addr", m_addr, ea)
            `CHK("hold_data", m_data, ed)
            `CHK("hold_grant", grant, oh)
            if (exp_plat < 0) `CHK("start_hs", m_start, plat <= mst_d1)
        end while ((ack | err) == '0 && plat < 60);
        `CHK("ack", ack, exp_err ? '0 : oh)
        `CHK("err", err, exp_err ? oh : '0)
        `CHK("lat", plat, exp_plat < 0 ? mst_d1 + mst_d2 + 1 : exp_plat)
        `CHK("cool_start", m_start, 1'b0)
        hold_low = 1'b0;
        req[w] = 1'b0;
        @(negedge clk);
        `CHK("idle_grant", grant, '0)
        `CHK("idle_busy", busy, 1'b0)
        `CHK("idle_pulse", ack | err, '0)
        last_m = w;
        if (rearm) req[w] = 1'b1;
    endtask

    initial begin
        int n;
        bit to;
        checks     = 0;
        errors     = 0;
        hold_low   = 1'b0;
        mst_ignore = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        reset      = 1'b0;
        last_m     = N - 1;

        do_reset();

        // single request
        req_addr[6:0] = 7'h20;
        req_data[7:0] = 8'hAA;
        req = 3'b001;
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);

        // simultaneous after reset: 0 then 1
        do_reset();
        req_addr[6:0]  = 7'h20; req_data[7:0]  = 8'hAA;
        req_addr[13:7] = 7'h21; req_data[15:8] = 8'hBB;
        req = 3'b011;
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);

        // fairness: both re-request immediately, grants alternate
        req = 3'b011;
        for (int i = 0; i < 4; i++) run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b1);
        req = '0;
        @(negedge clk);

        // ready low at request time
        hold_low = 1'b1;
        req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            `CHK("rl_grant", grant, '0)
            `CHK("rl_start", m_start, 1'b0)
        end
        hold_low = 1'b0;
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);

        // timeout in LAUNCH, then a normal transaction
        mst_ignore = 1'b1;
        req = 3'b100;
        req_addr[20:14] = 7'h33; req_data[23:16] = 8'h5C;
        run_txn(1'b1, TO, 1, 1'b0, 1'b0, 1'b0);
        mst_ignore = 1'b0;
        req = 3'b001;
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);

        // timeout in WAIT
        mst_ignore = 1'b1;
        req = 3'b010;
        run_txn(1'b1, TO + 1, 1, 1'b1, 1'b0, 1'b0);
        mst_ignore = 1'b0;

        // reset in WAIT; pointer returns so requester 0 wins next
        req = 3'b010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < 40);
        `CHK("rw_grant", grant, 3'b010)
        n = 0;
        while (m_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        `CHK("rw_in_wait", {m_start, |grant, busy}, 3'b011)
        req[0] = 1'b1;
        #2 reset = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        last_m = N - 1;
        run_txn(1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
        `CHK("rw_order", last_m, 0)
        run_txn(1'b0, -1, 1, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    req_addr[7*i +: 7] = 7'($urandom);
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if (req == '0) req[0] = 1'b1;
            to = ($urandom_range(0, 7) == 0);
            mst_ignore = to;
            run_txn(to, to ? TO : -1, 1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            mst_ignore = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
